// File: rtl/mm_bram_result_drain.sv
// Result-matrix drain: per-column row banks fill independently; complete rows are
// streamed out strictly in row order over a valid/ready port, with a done pulse per pass.
module mm_bram_result_drain #(
    parameter int DATA_WIDTH     = 8,
    parameter int ROW_NUM        = 32,
    parameter int COL_NUM        = 32,
    parameter int ROW_ADDR_WIDTH = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH*COL_NUM-1:0]     row_data_in,
    input  logic [ROW_ADDR_WIDTH*COL_NUM-1:0] row_wraddr,
    input  logic [COL_NUM-1:0]                row_wr_en,
    output logic                              out_val,
    input  logic                              out_rdy,
    output logic [DATA_WIDTH*COL_NUM-1:0]     out_data,
    output logic [ROW_ADDR_WIDTH-1:0]         out_row_addr,
    output logic                              done,
    output logic [1:0]                        o_dbg_state
);

    // Handshake: a row transfers on every rising edge where out_val && out_rdy;
    // while out_val is high and out_rdy low, out_data and out_row_addr are frozen.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_VALID = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [DATA_WIDTH-1:0]           r_bank [COL_NUM][ROW_NUM];
    logic [COL_NUM-1:0]              r_bitmap [ROW_NUM];
    logic [COL_NUM-1:0]              w_bitmap_next [ROW_NUM];
    logic [ROW_ADDR_WIDTH-1:0]       r_rd_ptr;
    logic [DATA_WIDTH*COL_NUM-1:0]   r_rd_data;
    logic [ROW_ADDR_WIDTH-1:0]       w_wr_addr [COL_NUM];
    logic [DATA_WIDTH-1:0]           w_wr_data [COL_NUM];
    logic [COL_NUM-1:0]              w_wr_ok;
    logic                            w_row_ready;
    logic                            w_last_row;
    logic                            w_rd_issue;
    logic                            w_latch;
    logic                            w_accept;

    // Out-of-range row addresses are dropped before they reach banks or bitmap.
    always_comb begin
        for (int c = 0; c < COL_NUM; c++) begin
            w_wr_addr[c] = row_wraddr[c*ROW_ADDR_WIDTH +: ROW_ADDR_WIDTH];
            w_wr_data[c] = row_data_in[c*DATA_WIDTH +: DATA_WIDTH];
            w_wr_ok[c]   = row_wr_en[c] && (32'(w_wr_addr[c]) < 32'(ROW_NUM));
        end
    end

    assign w_row_ready = &r_bitmap[r_rd_ptr];
    assign w_last_row  = (r_rd_ptr == ROW_ADDR_WIDTH'(ROW_NUM - 1));
    assign o_dbg_state = r_state;

    // Bank storage is never reset; the read port captures bank data one cycle after issue.
    always_ff @(posedge clk) begin
        for (int c = 0; c < COL_NUM; c++) begin
            if (w_wr_ok[c]) begin
                r_bank[c][w_wr_addr[c]] <= w_wr_data[c];
            end
        end
        if (w_rd_issue) begin
            for (int c = 0; c < COL_NUM; c++) begin
                r_rd_data[c*DATA_WIDTH +: DATA_WIDTH] <= r_bank[c][r_rd_ptr];
            end
        end
    end

    // The accept clear is applied first so a same-cycle write to that row survives.
    always_comb begin
        for (int r = 0; r < ROW_NUM; r++) begin
            w_bitmap_next[r] = r_bitmap[r];
            if (w_accept && (r_rd_ptr == ROW_ADDR_WIDTH'(r))) begin
                w_bitmap_next[r] = '0;
            end
            for (int c = 0; c < COL_NUM; c++) begin
                if (w_wr_ok[c] && (w_wr_addr[c] == ROW_ADDR_WIDTH'(r))) begin
                    w_bitmap_next[r][c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_issue   = 1'b0;
        w_latch      = 1'b0;
        w_accept     = 1'b0;
        out_val      = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_row_ready) begin
                    w_rd_issue   = 1'b1;
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                w_latch      = 1'b1;
                w_state_next = S_VALID;
            end
            S_VALID: begin
                out_val = 1'b1;
                if (out_rdy) begin
                    w_accept     = 1'b1;
                    w_state_next = w_last_row ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rd_ptr     <= '0;
            out_data     <= '0;
            out_row_addr <= '0;
            for (int r = 0; r < ROW_NUM; r++) begin
                r_bitmap[r] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                out_data     <= r_rd_data;
                out_row_addr <= r_rd_ptr;
            end
            if (w_accept) begin
                r_rd_ptr <= w_last_row ? '0 : r_rd_ptr + 1'b1;
            end
            for (int r = 0; r < ROW_NUM; r++) begin
                r_bitmap[r] <= w_bitmap_next[r];
            end
        end
    end

endmodule

// File: tb/tb_mm_bram_result_drain.sv
// Bench for mm_bram_result_drain: directed scenarios plus random fill/drain, checked by
// a row-level reference model feeding an expected queue that a negedge monitor consumes.
module tb_mm_bram_result_drain;

    localparam int DW  = 8;
    localparam int RN  = 4;
    localparam int CN  = 4;
    localparam int AW  = 2;
    localparam int RN5 = 5;
    localparam int AW5 = 3;
    localparam int IW  = AW + DW*CN;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [DW*CN-1:0] row_data_in = '0;
    logic [AW*CN-1:0] row_wraddr = '0;
    logic [CN-1:0]    row_wr_en = '0;
    logic             out_val;
    logic             out_rdy = 1'b0;
    logic [DW*CN-1:0] out_data;
    logic [AW-1:0]    out_row_addr;
    logic             done;
    logic [1:0]       dbg_state;

    logic [DW*CN-1:0]  data_b = '0;
    logic [AW5*CN-1:0] wraddr_b = '0;
    logic [CN-1:0]     wr_en_b = '0;
    logic              out_val_b;
    logic              out_rdy_b = 1'b1;
    logic [DW*CN-1:0]  out_data_b;
    logic [AW5-1:0]    out_row_addr_b;
    logic              done_b;
    logic [1:0]        dbg_state_b;

    always #5 clk = ~clk;

    mm_bram_result_drain #(.DATA_WIDTH(DW), .ROW_NUM(RN), .COL_NUM(CN)) u_dut (
        .clk(clk), .reset(reset), .row_data_in(row_data_in), .row_wraddr(row_wraddr),
        .row_wr_en(row_wr_en), .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
        .out_row_addr(out_row_addr), .done(done), .o_dbg_state(dbg_state)
    );

    mm_bram_result_drain #(.DATA_WIDTH(DW), .ROW_NUM(RN5), .COL_NUM(CN)) u_dut5 (
        .clk(clk), .reset(reset), .row_data_in(data_b), .row_wraddr(wraddr_b),
        .row_wr_en(wr_en_b), .out_val(out_val_b), .out_rdy(out_rdy_b), .out_data(out_data_b),
        .out_row_addr(out_row_addr_b), .done(done_b), .o_dbg_state(dbg_state_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: row contents, written-column sets, and the next row to be queued.
    logic [IW-1:0]    exp_q[$];
    logic [DW-1:0]    m_data [RN][CN];
    logic [CN-1:0]    m_bm [RN];
    bit               m_pushed [RN];
    int               m_ptr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int r = 0; r < RN; r++) begin
            m_bm[r]     = '0;
            m_pushed[r] = 1'b0;
        end
        m_ptr = 0;
    endtask

    // Rows leave in row order, so queue complete rows only as the order pointer reaches them.
    task automatic model_push();
        logic [DW*CN-1:0] d;
        while (m_bm[m_ptr] == 4'hF && !m_pushed[m_ptr]) begin
            for (int c = 0; c < CN; c++) d[c*DW +: DW] = m_data[m_ptr][c];
            exp_q.push_back({AW'(m_ptr), d});
            m_pushed[m_ptr] = 1'b1;
            m_ptr = (m_ptr + 1) % RN;
        end
    endtask

    // Called just after a rising edge; the write lands on the next edge.
    task automatic write_cycle(input logic [CN-1:0] en, input logic [AW*CN-1:0] addr,
                               input logic [DW*CN-1:0] data);
        int r;
        row_wr_en   = en;
        row_wraddr  = addr;
        row_data_in = data;
        @(posedge clk); #1;
        row_wr_en = '0;
        for (int c = 0; c < CN; c++) begin
            if (en[c]) begin
                r = int'(addr[c*AW +: AW]);
                m_data[r][c] = data[c*DW +: DW];
                m_bm[r][c]   = 1'b1;
            end
        end
        model_push();
    endtask

    task automatic write_row(input int r, input logic [DW*CN-1:0] data);
        logic [AW*CN-1:0] a;
        for (int c = 0; c < CN; c++) a[c*AW +: AW] = AW'(r);
        write_cycle(4'hF, a, data);
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || out_val || dbg_state != 2'd0) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        n_vec++;
        if (k >= 300) begin
            n_err++;
            $display("FAIL drain_timeout: %0d rows still expected after %0d cycles", exp_q.size(), k);
        end
    endtask

    task automatic wait_val(input string name);
        int k = 0;
        while (!out_val && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, out_val, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Monitor: pops and compares on every accepted row; also checks hold stability and done.
    bit            hold_prev = 1'b0;
    bit            done_exp = 1'b0;
    logic [IW-1:0] hold_val;
    logic [IW-1:0] got;

    always @(negedge clk) begin
        if (reset) begin
            hold_prev = 1'b0;
            done_exp  = 1'b0;
        end else begin
            if (done_exp || done) begin
                check("done_pulse", done, done_exp);
                check("done_no_val", out_val, 1'b0);
            end
            done_exp = 1'b0;
            if (hold_prev) begin
                check("hold_val", out_val, 1'b1);
                check("hold_row", {out_row_addr, out_data}, hold_val);
            end
            hold_prev = 1'b0;
            if (out_val) begin
                got = {out_row_addr, out_data};
                if (!out_rdy) begin
                    hold_prev = 1'b1;
                    hold_val  = got;
                end else begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_row: got row %0d data %h, expected none",
                                 out_row_addr, out_data);
                    end else begin
                        check("row", got, exp_q.pop_front());
                    end
                    m_bm[out_row_addr]     = '0;
                    m_pushed[out_row_addr] = 1'b0;
                    if (out_row_addr == AW'(RN - 1)) done_exp = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [CN-1:0]    en;
        logic [AW*CN-1:0] a;
        logic [DW*CN-1:0] d;
        int               seen;
        int               ra;

        model_reset();
        #1;
        check("rst_val", out_val, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data", out_data, '0);
        check("rst_addr", out_row_addr, '0);
        do_reset();

        // Single-cycle full-row write: out_val rises three cycles later.
        @(posedge clk); #1;
        out_rdy = 1'b1;
        write_row(0, 32'h04030201);
        @(negedge clk); check("lat_c1", out_val, 1'b0);
        @(negedge clk); check("lat_c2", out_val, 1'b0);
        @(negedge clk); check("lat_c3", out_val, 1'b1);
        @(posedge clk); #1;
        wait_drain();

        // Row 1 completes first, but row 0 still leaves first.
        do_reset();
        write_row(1, $urandom());
        d = $urandom();
        for (int c = 0; c < CN; c++) write_cycle(CN'(1 << c), '0, d);
        wait_drain();

        // Rows 2,3 bring the pointer back to 0; then a full pass under 10 cycles of stall.
        write_row(2, $urandom());
        write_row(3, $urandom());
        wait_drain();
        out_rdy = 1'b0;
        for (int r = 0; r < RN; r++) write_row(r, $urandom());
        repeat (10) begin @(posedge clk); #1; end
        check("stall_val", out_val, 1'b1);
        check("stall_addr", out_row_addr, 2'd0);
        out_rdy = 1'b1;
        wait_drain();

        // Random fill with random backpressure; writes avoid rows already complete.
        for (int i = 0; i < 600; i++) begin
            en = CN'($urandom_range(0, 15));
            d  = $urandom();
            for (int c = 0; c < CN; c++) begin
                ra = $urandom_range(0, RN - 1);
                a[c*AW +: AW] = AW'(ra);
                if (m_bm[ra] == 4'hF) en[c] = 1'b0;
            end
            out_rdy = ($urandom_range(0, 3) != 0);
            write_cycle(en, a, d);
        end
        out_rdy = 1'b1;
        wait_drain();

        // Reset while a row is presented: out_val drops without a clock edge.
        out_rdy = 1'b0;
        write_row(m_ptr, $urandom());
        wait_val("pre_reset_val");
        #2 reset = 1'b1;
        #1;
        check("async_rst_val", out_val, 1'b0);
        check("async_rst_data", out_data, '0);
        check("async_rst_addr", out_row_addr, '0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        out_rdy = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_val) seen++;
        end
        check("post_rst_quiet", seen, 0);

        // Write to column 2 of the row being accepted in the same cycle survives the clear.
        out_rdy = 1'b0;
        write_row(0, $urandom());
        wait_val("race_val");
        out_rdy     = 1'b1;
        row_wr_en   = 4'b0100;
        row_wraddr  = '0;
        row_data_in = 32'h00550000;
        @(posedge clk); #1;
        row_wr_en = '0;
        m_data[0][2] = 8'h55;
        m_bm[0][2]   = 1'b1;
        for (int r = 1; r < RN; r++) write_row(r, $urandom());
        wait_drain();
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_val) seen++;
        end
        check("race_partial_quiet", seen, 0);
        write_cycle(4'b1011, '0, $urandom());
        wait_drain();

        // Out-of-range rows on a 5-row instance: nothing written, nothing emitted.
        wr_en_b  = 4'hF;
        wraddr_b = {3'd5, 3'd6, 3'd7, 3'd5};
        data_b   = $urandom();
        @(posedge clk); #1;
        wraddr_b = {3'd6, 3'd6, 3'd6, 3'd6};
        @(posedge clk); #1;
        wr_en_b = '0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_val_b) seen++;
        end
        check("oor_quiet", seen, 0);
        d        = $urandom();
        wr_en_b  = 4'b0111;
        wraddr_b = '0;
        data_b   = d;
        @(posedge clk); #1;
        wr_en_b = '0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_val_b) seen++;
        end
        check("oor_bitmap_partial", seen, 0);
        wr_en_b = 4'b1000;
        data_b  = {8'hA7, 24'h0};
        @(posedge clk); #1;
        wr_en_b = '0;
        seen = 0;
        while (!out_val_b && seen < 20) begin
            @(posedge clk); #1;
            seen++;
        end
        check("oor_row_val", out_val_b, 1'b1);
        check("oor_row_data", out_data_b, {8'hA7, d[23:0]});
        check("oor_row_addr", out_row_addr_b, 3'd0);
        repeat (4) begin @(posedge clk); #1; end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mm_bram_result_drain.md
MM_BRAM_RESULT_DRAIN -- requirements
Module: mm_bram_result_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter ROW_NUM, default 32, rows per result matrix.
REQ-003 SHALL have parameter COL_NUM, default 32, columns; one storage bank per column.
REQ-004 SHALL have derived parameter ROW_ADDR_WIDTH, default $clog2(ROW_NUM), row address width; not set manually.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port row_data_in  input  DATA_WIDTH*COL_NUM  per-column write data; slice c feeds bank c.
REQ-008 SHALL have port row_wraddr  input  ROW_ADDR_WIDTH*COL_NUM  per-column write row address; slice c addresses bank c.
REQ-009 SHALL have port row_wr_en  input  COL_NUM  per-column write enable; bit c enables bank c.
REQ-010 SHALL have port out_val  output  1  drained row valid.
REQ-011 SHALL have port out_rdy  input  1  downstream ready.
REQ-012 SHALL have port out_data  output  DATA_WIDTH*COL_NUM  drained row; slice c from bank c.
REQ-013 SHALL have port out_row_addr  output  ROW_ADDR_WIDTH  row index of out_data.
REQ-014 SHALL have port done  output  1  one-cycle pulse after row ROW_NUM-1 is accepted.

Function
REQ-015 SHALL hold COL_NUM banks of ROW_NUM x DATA_WIDTH; per bank: synchronous write, registered read with 1-cycle latency.
REQ-016 SHALL keep a per-row COL_NUM-bit written bitmap; a write sets bit c of row row_wraddr[c]; row is ready when all COL_NUM bits are set.
REQ-017 SHALL ignore writes with row address >= ROW_NUM: no bank write, no bitmap change.
REQ-018 SHALL overwrite bank data on a repeated write to the same (row, column); the bitmap bit stays set.
REQ-019 SHALL drain rows strictly in order from rd_ptr (reset 0), never skipping a non-ready row.
REQ-020 SHALL implement the FSM states IDLE, READ, VALID, DONE.
REQ-021 IDLE: if row rd_ptr is ready, SHALL issue a bank read of rd_ptr and go to READ; otherwise stay in IDLE.
REQ-022 READ: SHALL latch the bank outputs into out_data, set out_row_addr=rd_ptr, and go to VALID.
REQ-023 VALID: out_val=1; out_data/out_row_addr SHALL stay stable while out_rdy=0.
REQ-024 On out_val&&out_rdy, SHALL clear the row rd_ptr bitmap. If rd_ptr==ROW_NUM-1, wrap rd_ptr to 0 and go to DONE; else increment rd_ptr and go to IDLE.
REQ-025 DONE: done=1 for exactly one cycle, out_val=0, then go to IDLE.
REQ-026 Latency: last completing write presented in cycle 0 SHALL give out_val=1 in cycle 3 (bitmap edge 1, read edge 2, latch edge 3).
REQ-027 A write that sets a bit of row rd_ptr in the same cycle as the accept clear SHALL win: that bit stays set, and the row is drained again on the next pass.
REQ-028 Writes to row rd_ptr during READ/VALID SHALL update the bank only; the latched out_data is unchanged.
REQ-029 Throughput: at most one row per 3 cycles; out_val SHALL be 0 in IDLE, READ and DONE.

Reset
REQ-030 On reset assertion, independent of clk, SHALL immediately force:
- FSM to IDLE
- rd_ptr to 0
- all bitmaps cleared
- out_val, done, out_data, out_row_addr to 0
REQ-031 Bank contents SHALL NOT be reset.
REQ-032 Reset mid-drain SHALL discard the in-flight row; nothing SHALL be emitted until rows are fully rewritten after reset release.

Verification
REQ-033 ROW_NUM=4, COL_NUM=4, DATA_WIDTH=8; write row 0 with all columns in one cycle, data {4,3,2,1}, out_rdy=1 -> out_val in cycle 3, out_data={4,3,2,1}, out_row_addr=0.
REQ-034 Write row 1 fully, then row 0 column by column over 4 cycles -> row 0 emitted first, then row 1; out_row_addr sequence 0,1.
REQ-035 All 4 rows complete, out_rdy=0 for 10 cycles then 1 -> out_data held stable for 10 cycles; rows 0..3 emitted; done pulses one cycle after row 3 accept; rd_ptr back to 0.
REQ-036 Same-cycle write of column 2 of row rd_ptr with data 0x55 during accept -> row stays with bit 2 set and is re-emitted only after the other columns are rewritten on the next pass.
REQ-037 Assert reset while in VALID -> out_val=0 immediately; with no new writes, out_val stays 0 for 20 cycles.
REQ-038 Write with row_wraddr=5 when ROW_NUM=4 (ROW_ADDR_WIDTH=2 makes 5 unrepresentable, so use ROW_NUM=5, row 6) -> no output, bitmap unchanged.
